// File: rtl/data_unpack.sv
// Unpacks framed 32-bit words into 7-bit MSB-first symbols; the first symbol follows acceptance by one cycle.
// The output side never stalls. ready_out throttles the source on buffer space and is held low while a packet drains.
module data_unpack (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        sop_in,
  input  logic        eop_in,
  input  logic [31:0] data_in,
  output logic        ready_out,
  output logic        valid_out,
  output logic        sop_out,
  output logic        eop_out,
  output logic [6:0]  data_out
);

  logic [37:0] bit_buf, buf_emit, buf_nxt;
  logic [5:0]  cnt, cnt_emit, cnt_nxt, take;
  logic        in_pkt, sop_pend, eop_pend;
  logic        in_pkt_nxt, sop_pend_nxt, eop_pend_nxt;
  logic        accept;

  always_comb begin
    valid_out = (cnt >= 6'd7) | (eop_pend & (cnt != 6'd0));
    data_out  = bit_buf[37:31];
    sop_out   = valid_out & sop_pend;
    eop_out   = valid_out & eop_pend & (cnt <= 6'd7);
    ready_out = rst & ~eop_pend & (cnt <= 6'd13);
    accept    = valid_in & ready_out;

    // Bits below cnt are always zero, so a short final symbol is padded for free.
    take     = valid_out ? ((cnt >= 6'd7) ? 6'd7 : cnt) : 6'd0;
    buf_emit = bit_buf << take;
    cnt_emit = cnt - take;

    buf_nxt      = buf_emit;
    cnt_nxt      = cnt_emit;
    in_pkt_nxt   = in_pkt & ~eop_out;
    sop_pend_nxt = sop_pend & ~valid_out;
    eop_pend_nxt = eop_pend & ~eop_out;

    if (accept) begin
      buf_nxt    = buf_emit | ({data_in, 6'b0} >> cnt_emit);
      cnt_nxt    = cnt_emit + 6'd32;
      in_pkt_nxt = 1'b1;
      if (sop_in && !in_pkt) begin
        sop_pend_nxt = 1'b1;
      end
      if (eop_in) begin
        eop_pend_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_buf  <= '0;
      cnt      <= '0;
      in_pkt   <= 1'b0;
      sop_pend <= 1'b0;
      eop_pend <= 1'b0;
    end else begin
      bit_buf  <= buf_nxt;
      cnt      <= cnt_nxt;
      in_pkt   <= in_pkt_nxt;
      sop_pend <= sop_pend_nxt;
      eop_pend <= eop_pend_nxt;
    end
  end

endmodule

// File: tb/tb_data_unpack.sv
// Directed bench for data_unpack: packets are driven by a ready-aware source and every symbol is
// checked against a bit-string reference plus hand-derived timing points.
module tb_data_unpack;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        sop_in = 1'b0;
  logic        eop_in = 1'b0;
  logic [31:0] data_in = '0;
  logic        ready_out, valid_out, sop_out, eop_out;
  logic [6:0]  data_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] words[8];
  int          nw;
  int          stall_idx;
  int          stall_len;
  logic [6:0]  sym_q[$];
  logic        sop_q[$];
  logic        eop_q[$];
  int          scyc_q[$];
  int          acc_q[$];
  int          last_eop_cyc;
  int          n_before;

  data_unpack dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sop_in(sop_in), .eop_in(eop_in),
    .data_in(data_in), .ready_out(ready_out), .valid_out(valid_out), .sop_out(sop_out),
    .eop_out(eop_out), .data_out(data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives words[0..nw-1] as one packet, collects every symbol up to eop_out, then
  // compares the symbol stream with the packet's bits sliced 7 at a time.
  task automatic run_pkt(input string tag, input bit contiguous);
    int   idx = 0;
    int   rem = 0;
    int   budget = 0;
    int   ready_viol = 0;
    int   n;
    bit   done = 0;
    bit   eop_acc = 0;
    logic bits[$];
    logic [6:0] e;
    sym_q.delete(); sop_q.delete(); eop_q.delete(); scyc_q.delete(); acc_q.delete();
    while (!done && budget < 300) begin
      step();
      budget++;
      if (valid_out) begin
        sym_q.push_back(data_out);
        sop_q.push_back(sop_out);
        eop_q.push_back(eop_out);
        scyc_q.push_back(cyc);
        if (eop_out) begin
          done = 1;
          last_eop_cyc = cyc;
        end
      end
      if (eop_acc && ready_out) ready_viol++;
      if (rem > 0) begin
        rem--;
        valid_in = 1'b0;
      end else if (idx < nw) begin
        valid_in = 1'b1;
        data_in  = words[idx];
        sop_in   = (idx == 0);
        eop_in   = (idx == nw - 1);
      end else begin
        valid_in = 1'b0;
      end
      if (valid_in && ready_out) begin
        acc_q.push_back(cyc);
        if (idx == nw - 1) eop_acc = 1;
        if (idx + 1 == stall_idx) rem = stall_len;
        idx++;
      end
    end
    valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
    if (!done) chk({tag, " eop timeout"}, 32'd0, 32'd1);

    for (int w = 0; w < nw; w++)
      for (int b = 31; b >= 0; b--) bits.push_back(words[w][b]);
    while (bits.size() % 7 != 0) bits.push_back(1'b0);

    chk({tag, " symbol count"}, sym_q.size(), bits.size() / 7);
    n = (sym_q.size() < bits.size() / 7) ? sym_q.size() : bits.size() / 7;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 7; j++) e[6-j] = bits[7*i+j];
      chk($sformatf("%s sym%0d", tag, i), sym_q[i], e);
      chk($sformatf("%s sop%0d", tag, i), sop_q[i], (i == 0));
      chk($sformatf("%s eop%0d", tag, i), eop_q[i], (i == n - 1));
      if (contiguous) chk($sformatf("%s gap%0d", tag, i), scyc_q[i], scyc_q[0] + i);
    end
    chk({tag, " ready low while draining"}, ready_viol, 0);
    chk({tag, " first symbol latency"}, scyc_q[0], acc_q[0] + 1);
  endtask

  initial begin
    stall_idx = -1;
    stall_len = 0;
    last_eop_cyc = 0;

    // Reset state
    #12;
    chk("rst ready_out", ready_out, 0);
    chk("rst valid_out", valid_out, 0);
    chk("rst data_out", data_out, 0);
    step();
    rst = 1'b1;
    #1;
    chk("post-rst ready_out", ready_out, 1);
    chk("post-rst valid_out", valid_out, 0);

    // One-word packet of all ones: 7F x4 then 78
    nw = 1; words[0] = 32'hFFFF_FFFF;
    run_pkt("ones", 1);
    chk("ones sym0", sym_q[0], 7'h7F);
    chk("ones sym4", sym_q[4], 7'h78);
    step();
    chk("ones ready after eop", ready_out, 1);

    // Two words with single set bits; second accepted when cnt reaches 11
    nw = 2; words[0] = 32'h8000_0000; words[1] = 32'h0000_0001;
    run_pkt("two", 1);
    chk("two accept spacing", acc_q[1] - acc_q[0], 4);
    chk("two sym0", sym_q[0], 7'h40);
    chk("two sym9", sym_q[9], 7'h40);

    // Seven words: 224 bits, no pad symbol
    nw = 7;
    for (int i = 0; i < 7; i++) words[i] = 32'h1234_5678;
    run_pkt("seven", 1);
    chk("seven count", sym_q.size(), 32);

    // Source stalls 5 cycles before the third word
    nw = 3; words[0] = 32'hDEAD_BEEF; words[1] = 32'h0F1E_2D3C; words[2] = 32'hA5A5_5A5A;
    stall_idx = 2; stall_len = 5;
    run_pkt("stall", 0);
    stall_idx = -1; stall_len = 0;
    n_before = 0;
    foreach (scyc_q[i]) if (scyc_q[i] <= acc_q[2]) n_before++;
    chk("stall symbols before resume", n_before, 9);
    chk("stall resume cycle", scyc_q[9], acc_q[2] + 1);

    // Back-to-back one-word packets
    nw = 1; words[0] = 32'h0000_000F;
    run_pkt("pkt1", 1);
    chk("pkt1 sym4", sym_q[4], 7'h78);
    words[0] = 32'hF000_0000;
    run_pkt("pkt2", 1);
    chk("pkt2 sym0", sym_q[0], 7'h78);
    chk("pkt2 sym1", sym_q[1], 7'h00);
    chk("pkt2 start", scyc_q[0], acc_q[0] + 1);

    // Reset mid-packet with cnt=25
    step();
    valid_in = 1'b1; sop_in = 1'b1; eop_in = 1'b0; data_in = 32'hAAAA_AAAA;
    chk("mid ready", ready_out, 1);
    step();
    valid_in = 1'b0; sop_in = 1'b0;
    chk("mid sym0", data_out, 7'h55);
    chk("mid sop0", sop_out, 1);
    step();
    chk("mid sym1", data_out, 7'h2A);
    rst = 1'b0;
    #1;
    chk("mid rst valid_out", valid_out, 0);
    chk("mid rst ready_out", ready_out, 0);
    chk("mid rst sop_out", sop_out, 0);
    chk("mid rst eop_out", eop_out, 0);
    chk("mid rst data_out", data_out, 0);
    step();
    rst = 1'b1;
    #1;
    chk("mid release ready_out", ready_out, 1);
    chk("mid release valid_out", valid_out, 0);
    nw = 1; words[0] = 32'h0000_007F;
    run_pkt("after rst", 1);
    chk("after rst sym3", sym_q[3], 7'h07);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
